turbo_enc_param: RTL and testbench
==================================

TURBO_ENC_PARAM -- requirements
Module: turbo_enc_param

Interface
REQ-001 SHALL have parameter K, default 16: block length in information bits (8..256).
REQ-002 SHALL have parameter A, default 5: interleaver step; gcd(A,K)=1 and 0<A<K are required, and elaboration SHALL fail otherwise.
REQ-003 SHALL have parameter B, default 0: interleaver offset, 0<=B<K.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port in_bit, input, 1: serial information bit.
REQ-007 SHALL have port in_valid, input, 1: in_bit is valid.
REQ-008 SHALL have port in_ready, output, 1: block accepts in_bit.
REQ-009 SHALL have port punct, input, 1: 0 = rate 1/3; 1 = rate 1/2 punctured.
REQ-010 SHALL have port out_data, output, 3: {sys, p1, p2}.
REQ-011 SHALL have port out_mask, output, 3: per-bit transmit flags, same order as out_data.
REQ-012 SHALL have port out_valid, output, 1: output word valid.
REQ-013 SHALL have port out_ready, input, 1: consumer accepts the output word.
REQ-014 SHALL have port out_last, output, 1: marks the final word of a block.

Function
REQ-015 SHALL use FSM states IDLE, LOAD, ENC, TAIL; from reset the FSM SHALL be in IDLE with in_ready=1.
REQ-016 A transfer SHALL occur when in_valid&&in_ready; the first transfer SHALL latch punct into a block-mode register, enter LOAD, and store the bit at buf[0].
REQ-017 Transfer j SHALL store the bit at buf[j]; after transfer K-1, in_ready SHALL drop and the FSM SHALL enter ENC in the next cycle.
REQ-018 in_ready SHALL be 0 in ENC and TAIL; punct changes after latching SHALL have no effect until the next block.
REQ-019 ENC SHALL emit K words, index i=0..K-1: sys=buf[i]; p1=RSC1(buf[i]); p2=RSC2(buf[pi(i)]), where pi(i)=(A*i+B) mod K.
REQ-020 pi SHALL be generated incrementally (start B, add A, subtract K when the sum is >=K); no multiplier.
REQ-021 Each RSC SHALL be memory-3 with state s1..s3 reset to 0; a=u^s2^s3; parity=a^s1^s3; shift (s1,s2,s3)<=(a,s1,s2).
REQ-022 TAIL SHALL emit 3 words; each encoder's input SHALL be u=s2^s3, forcing a=0.
REQ-023 In TAIL, sys SHALL be RSC1's tail input, p1=RSC1 parity, p2=RSC2 parity; RSC2's tail input SHALL NOT be transmitted.
REQ-024 After TAIL, both RSC states SHALL equal 0.
REQ-025 out_mask SHALL follow the mode: rate 1/3 -> 111; rate 1/2 in ENC -> 110 for even i and 101 for odd i; TAIL -> 111.
REQ-026 Rate 1/2 SHALL leave out_data contents unchanged; masked bits still carry their computed values.
REQ-027 out_valid SHALL assert the cycle after ENC entry; each word SHALL be held stable until out_valid&&out_ready.
REQ-028 Encoder state and indices SHALL advance only on output handshake.
REQ-029 out_last SHALL be 1 only on the 3rd TAIL word; its handshake SHALL return the FSM to IDLE with in_ready=1 in the next cycle.
REQ-030 Each block SHALL produce exactly K+3 output words.

Reset
REQ-031 Asserting rst_n=0 SHALL immediately force: IDLE, in_ready=1, out_valid=0, out_last=0, out_data=000, out_mask=000, RSC states 0, indices 0, pi register=B.
REQ-032 Reset in any state SHALL abandon the partial block; no stale word SHALL appear after rst_n release.
REQ-033 buf contents need not be reset.

Structure
REQ-034 A shared package SHALL hold the FSM state enum, the RSC tap constants, and the mask constants MASK_FULL=111, MASK_EVEN=110, MASK_ODD=101.
REQ-035 One sub-module, rsc_enc, SHALL implement a single RSC encoder (step, terminate and clear controls); it SHALL be instantiated twice.

Verification
REQ-036 K=8, A=3, B=0, all-zero block, punct=0 -> 11 words, all out_data=000, out_mask=111, out_last on word 11.
REQ-037 K=8, A=3, B=0, input 0100_0000 (bit1=1), punct=0 -> pi sequence 0,3,6,1,4,7,2,5; p1 words 0-4 = 0,1,1,1,1; p2 words 0-3 = 0,0,0,1; both RSCs zero after TAIL.
REQ-038 Same stimulus with punct=1 -> masks 110,101,110,101,110,101,110,101,111,111,111; out_data identical to REQ-037.
REQ-039 out_ready toggled pseudo-randomly -> out_data/out_mask stable while stalled; sequence identical to the no-stall run; in_ready stays 0 until the out_last handshake.
REQ-040 rst_n pulsed low during ENC word 4 -> outputs at reset values that cycle; a following full block encodes correctly from IDLE.
REQ-041 punct toggled mid-LOAD -> the mode latched at the first bit governs the whole block.

Source files
------------

// File: rtl/turbo_enc_param_pkg.sv
// turbo_enc_param_pkg: shared FSM states, RSC taps, puncturing masks and parameter helpers
package turbo_enc_param_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, ENC, TAIL} state_t;
    // RSC state vector is {s1, s2, s3}; feedback taps s2^s3, feedforward taps s1^s3
    localparam logic [2:0] RSC_FB    = 3'b011;
    localparam logic [2:0] RSC_FF    = 3'b101;
    localparam logic [2:0] MASK_FULL = 3'b111;
    localparam logic [2:0] MASK_EVEN = 3'b110;
    localparam logic [2:0] MASK_ODD  = 3'b101;
    function automatic int gcd(input int a, input int b);
        int x = a;
        int y = b;
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction
endpackage

// File: rtl/turbo_enc_param_rsc.sv
// rsc_enc: one memory-3 recursive systematic convolutional encoder with step/terminate/clear
module rsc_enc
    import turbo_enc_param_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic step_i,
    input  logic term_i,
    input  logic clr_i,
    input  logic u_i,
    output logic u_o,
    output logic par_o
);
    logic [2:0] s_q, s_d;
    logic       fb, a;
    always_comb begin
        fb    = ^(s_q & RSC_FB);
        u_o   = term_i ? fb : u_i;
        a     = u_o ^ fb;
        par_o = a ^ (^(s_q & RSC_FF));
        s_d   = clr_i ? 3'b000 : step_i ? {a, s_q[2:1]} : s_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s_q <= 3'b000;
        else        s_q <= s_d;
    end
endmodule

// File: rtl/turbo_enc_param.sv
// turbo_enc_param: parallel-concatenated turbo encoder, K-bit block buffer, two RSCs,
// linear-congruential interleaver and optional rate-1/2 puncturing via out_mask.
module turbo_enc_param
    import turbo_enc_param_pkg::*;
#(
    parameter int K = 16,
    parameter int A = 5,
    parameter int B = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_bit,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       punct,
    output logic [2:0] out_data,
    output logic [2:0] out_mask,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last
);
    localparam int IW = $clog2(K);
    if (K < 8 || K > 256 || A <= 0 || A >= K || B < 0 || B >= K || gcd(A, K) != 1) begin : g_bad_param
        $error("turbo_enc_param: illegal K/A/B combination");
    end
    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d, pi_q, pi_d;
    logic [IW:0]   pi_sum, pi_nx;
    logic          mode_q, mode_d, vld_q, vld_d;
    logic [K-1:0]  bits_q;
    logic          in_xfer, out_xfer, term, last_idx, tail_end;
    logic          sys, par1, par2, unused_tu2;
    logic [2:0]    mask;
    always_comb begin
        in_ready  = state_q == IDLE || state_q == LOAD;
        out_valid = vld_q;
        in_xfer   = in_valid && in_ready;
        out_xfer  = vld_q && out_ready;
        term      = state_q == TAIL;
        last_idx  = idx_q == IW'(K - 1);
        tail_end  = idx_q == IW'(2);
        pi_sum    = {1'b0, pi_q} + (IW + 1)'(A);
        pi_nx     = pi_sum >= (IW + 1)'(K) ? pi_sum - (IW + 1)'(K) : pi_sum;
        mask      = (term || !mode_q) ? MASK_FULL : idx_q[0] ? MASK_ODD : MASK_EVEN;
        out_data  = vld_q ? {sys, par1, par2} : 3'b000;
        out_mask  = vld_q ? mask : 3'b000;
        out_last  = vld_q && term && tail_end;
    end
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pi_d    = pi_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: if (in_xfer) begin
                mode_d  = punct;
                idx_d   = IW'(1);
                state_d = LOAD;
            end
            LOAD: if (in_xfer) begin
                idx_d   = last_idx ? '0 : idx_q + 1'b1;
                state_d = last_idx ? ENC : LOAD;
            end
            ENC: if (out_xfer) begin
                pi_d    = pi_nx[IW-1:0];
                idx_d   = last_idx ? '0 : idx_q + 1'b1;
                state_d = last_idx ? TAIL : ENC;
            end
            default: if (out_xfer) begin
                idx_d   = tail_end ? '0 : idx_q + 1'b1;
                state_d = tail_end ? IDLE : TAIL;
            end
        endcase
        // the first word becomes valid one cycle after the FSM lands in ENC
        vld_d = (state_q == ENC || state_q == TAIL) && (state_d == ENC || state_d == TAIL);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pi_q    <= IW'(B);
            mode_q  <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pi_q    <= pi_d;
            mode_q  <= mode_d;
            vld_q   <= vld_d;
        end
    end
    always_ff @(posedge clk) begin
        if (in_xfer) bits_q[idx_q] <= in_bit;
    end
    rsc_enc u_rsc1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .step_i (out_xfer),
        .term_i (term),
        .clr_i  (state_q == IDLE),
        .u_i    (bits_q[idx_q]),
        .u_o    (sys),
        .par_o  (par1)
    );
    rsc_enc u_rsc2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .step_i (out_xfer),
        .term_i (term),
        .clr_i  (state_q == IDLE),
        .u_i    (bits_q[pi_q]),
        .u_o    (unused_tu2),
        .par_o  (par2)
    );
endmodule

// File: tb/tb_turbo_enc_param.sv
// tb_turbo_enc_param: randomized and directed checks of turbo_enc_param against a behavioural model
module tb_turbo_enc_param;
    localparam int K = 8;
    localparam int A = 3;
    localparam int B = 0;
    logic       clk, rst_n, in_bit, in_valid, in_ready, punct, out_valid, out_ready, out_last;
    logic [2:0] out_data, out_mask;
    int         checks = 0;
    int         failures = 0;
    logic [6:0] exp_q[$];
    logic [6:0] got[$];
    logic [2:0] ref_data[$];

    turbo_enc_param #(.K(K), .A(A), .B(B)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .punct     (punct),
        .out_data  (out_data),
        .out_mask  (out_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got_v, exp_v);
        end
    endtask

    // expected word stream {last, mask, sys, p1, p2} straight from the encoder equations
    function automatic void build(input logic [K-1:0] blk, input bit mode);
        int s[2][3];
        int u[2];
        int p[2];
        int a;
        int m;
        for (int e = 0; e < 2; e++) for (int k = 0; k < 3; k++) s[e][k] = 0;
        exp_q.delete();
        for (int i = 0; i < K + 3; i++) begin
            for (int e = 0; e < 2; e++) begin
                if (i < K) u[e] = (e == 0) ? int'(blk[i]) : int'(blk[(A * i + B) % K]);
                else       u[e] = s[e][1] ^ s[e][2];
                a = u[e] ^ s[e][1] ^ s[e][2];
                p[e] = a ^ s[e][0] ^ s[e][2];
                s[e][2] = s[e][1];
                s[e][1] = s[e][0];
                s[e][0] = a;
            end
            m = (i >= K || !mode) ? 7 : ((i % 2) ? 5 : 6);
            exp_q.push_back({i == K + 2, m[2:0], u[0][0], p[0][0], p[1][0]});
        end
    endfunction

    task automatic load_block(input logic [K-1:0] blk, input bit mode, input bit toggle);
        build(blk, mode);
        got.delete();
        for (int j = 0; j < K; j++) begin
            repeat ($urandom_range(0, 1)) begin
                @(negedge clk);
                in_valid = 1'b0;
                punct = toggle ? 1'($urandom) : mode;
            end
            @(negedge clk);
            chk("in_ready_load", in_ready, 1);
            in_valid = 1'b1;
            in_bit = blk[j];
            punct = (j == 0 || !toggle) ? mode : 1'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_bit = 1'b0;
    endtask

    task automatic drain(input bit stall, input int abort_at);
        int n = 0;
        int words = 0;
        int first = -1;
        bit held = 0;
        bit done = 0;
        logic [6:0] prev = '0;
        logic [6:0] e;
        while (!done && n < 300) begin
            if (out_valid && first < 0) first = n;
            if (held) chk("hold", {out_valid, out_data, out_mask}, prev);
            if (out_valid) chk("in_ready_busy", in_ready, 0);
            if (abort_at >= 0 && words == abort_at && out_valid) return;
            out_ready = stall ? 1'($urandom) : 1'b1;
            if (out_valid && out_ready) begin
                e = exp_q.size() > 0 ? exp_q.pop_front() : 7'h7f;
                chk("word", {out_last, out_mask, out_data}, e);
                got.push_back({out_last, out_mask, out_data});
                words++;
                done = out_last;
                held = 0;
            end else begin
                held = out_valid;
                prev = {out_valid, out_data, out_mask};
            end
            @(negedge clk);
            n++;
        end
        out_ready = 1'b0;
        chk("drain_done", done, 1);
        chk("idle_ready", in_ready, 1);
        chk("first_latency", first, 1);
        chk("word_count", words, K + 3);
    endtask

    task automatic check_reset_outputs();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_mask", out_mask, 0);
        chk("rst_out_last", out_last, 0);
    endtask

    initial begin
        logic [K-1:0] blk;
        logic [4:0]   p1_ref = 5'b11110;
        logic [3:0]   p2_ref = 4'b1000;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_bit = 1'b0;
        punct = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);

        load_block('0, 1'b0, 1'b0);
        drain(1'b0, -1);

        blk = 8'b0000_0010;
        load_block(blk, 1'b0, 1'b0);
        drain(1'b0, -1);
        for (int i = 0; i < 5; i++) chk("p1_directed", got[i][1], p1_ref[i]);
        for (int i = 0; i < 4; i++) chk("p2_directed", got[i][0], p2_ref[i]);
        ref_data.delete();
        foreach (got[i]) ref_data.push_back(got[i][2:0]);

        load_block(blk, 1'b1, 1'b0);
        drain(1'b0, -1);
        foreach (got[i]) chk("punct_data_same", got[i][2:0], ref_data[i]);

        load_block(blk, 1'b0, 1'b0);
        drain(1'b1, -1);
        foreach (got[i]) chk("stall_data_same", got[i][2:0], ref_data[i]);

        load_block(K'($urandom), 1'b1, 1'b1);
        drain(1'b1, -1);

        load_block(K'($urandom), 1'b0, 1'b0);
        drain(1'b0, 4);
        rst_n = 1'b0;
        out_ready = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        load_block(K'($urandom), 1'b1, 1'b0);
        drain(1'b0, -1);

        for (int b = 0; b < 10; b++) begin
            load_block(K'($urandom), 1'($urandom), 1'($urandom));
            drain(1'($urandom), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
